// File: rtl/t07_ssdec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : t07_ssdec_pkg
// Purpose  : Shared types, default parameters and the frame-packing helper
//            for the seven-segment decoder serial link.
// Revision : 1.0  initial release
// ============================================================================
package t07_ssdec_pkg;

  // Transmitter phases. The select line is low through SHIFT_LO,
  // SHIFT_HI and HOLD.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    HOLD     = 3'd3,
    GAP      = 3'd4
  } ssdec_tx_state_t;

  // Defaults: a 16-bit frame, a 1 MHz SCK from a 12 MHz clk, and a
  // 4-cycle inter-frame gap.
  localparam int SSDEC_DATA_W   = 16;
  localparam int SSDEC_HALF_DIV = 6;
  localparam int SSDEC_GAP      = 4;

  // Build a decoder frame: lives in [11:10], minutes in [9:7], tens of
  // seconds in [6:4], units of seconds in [3:0]. Bits [15:12] are zero.
  function automatic logic [15:0] pack_frame(
    input logic [1:0] lives,
    input logic [2:0] cnt_min,
    input logic [2:0] cnt_sec_ten,
    input logic [3:0] cnt_sec_one
  );
    return {4'b0000, lives, cnt_min, cnt_sec_ten, cnt_sec_one};
  endfunction

endpackage : t07_ssdec_pkg
`default_nettype wire

// File: rtl/t07_ssdec_tick.sv
`default_nettype none
// ============================================================================
// Module   : t07_ssdec_tick
// Purpose  : Phase divider. While enabled, emits a one-cycle phase tick
//            every HALF_DIV clk cycles; the count is held at zero whenever
//            disabled, so each enable starts a full phase.
// Revision : 1.0  initial release
// ============================================================================
module t07_ssdec_tick #(
  parameter int HALF_DIV = 6
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_en,
  output logic o_phase_tick
);

  localparam int                 c_CNT_W = $clog2(HALF_DIV + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HALF_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_LAST);

  // Count the cycles of the current phase; wrap to zero when it ends.
  always_ff @(posedge clk) begin
    if (!nrst || !i_en) begin
      r_cnt <= '0;
    end else if (w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  // The tick marks the last cycle of a phase, so the FSM changes phase
  // on the edge that closes exactly HALF_DIV cycles.
  always_comb begin
    o_phase_tick = i_en && w_at_last;
  end

endmodule : t07_ssdec_tick
`default_nettype wire

// File: rtl/t07_ssdec_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : t07_ssdec_spi_tx
// Purpose  : SPI mode-0 transmitter feeding the external seven-segment
//            decoder board. Accepts one parallel frame over valid/ready and
//            shifts it out MSB-first with an active-low select, then holds
//            select high for a fixed gap before accepting the next frame.
// Revision : 1.0  initial release
// ============================================================================
module t07_ssdec_spi_tx
  import t07_ssdec_pkg::*;
#(
  parameter int DATA_W   = SSDEC_DATA_W,
  parameter int HALF_DIV = SSDEC_HALF_DIV,
  parameter int GAP      = SSDEC_GAP
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_tx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_ready,
  output logic              o_tx_done,
  output logic              o_ssdec_sdi,
  output logic              o_ssdec_sck,
  output logic              o_ssdec_ss
);

  localparam int                 c_BIT_W    = $clog2(DATA_W);
  localparam int                 c_GAP_W    = $clog2(GAP + 1);
  localparam logic [c_BIT_W-1:0] c_BIT_TOP  = c_BIT_W'(DATA_W - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

  // The module parameter GAP shares its name with the enum literal, so
  // the literal is always referenced through the package scope.
  localparam ssdec_tx_state_t c_ST_GAP = t07_ssdec_pkg::GAP;

  ssdec_tx_state_t     r_state;
  ssdec_tx_state_t     w_state_nxt;
  logic [DATA_W-1:0]   r_shreg;
  logic [DATA_W-1:0]   w_shreg_nxt;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [c_BIT_W-1:0]  w_bit_cnt_nxt;
  logic [c_GAP_W-1:0]  r_gap_cnt;
  logic [c_GAP_W-1:0]  w_gap_cnt_nxt;
  logic                r_done;
  logic                w_done_nxt;

  logic                w_busy;
  logic                w_tick;
  logic                w_last_bit;
  logic                w_gap_end;

  // Select is asserted for the whole shift and hold window.
  assign w_busy     = (r_state == SHIFT_LO) || (r_state == SHIFT_HI) ||
                      (r_state == HOLD);
  assign w_last_bit = (r_bit_cnt == '0);
  assign w_gap_end  = (r_state == c_ST_GAP) && (r_gap_cnt == c_GAP_LAST);

  t07_ssdec_tick #(
    .HALF_DIV     (HALF_DIV)
  ) u_tick (
    .clk          (clk),
    .nrst         (nrst),
    .i_en         (w_busy),
    .o_phase_tick (w_tick)
  );

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: phases advance on the divider tick, the gap on its counter.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_tx_valid) begin
          w_state_nxt = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (w_tick) begin
          w_state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (w_tick) begin
          w_state_nxt = w_last_bit ? HOLD : SHIFT_LO;
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_state_nxt = c_ST_GAP;
        end
      end
      c_ST_GAP: begin
        if (w_gap_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath next values: frame capture, shifting, bit/gap counting and
  // the end-of-frame pulse.
  always_comb begin
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = '0;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        // tx_data is only looked at on the accept edge.
        if (i_tx_valid) begin
          w_shreg_nxt   = i_tx_data;
          w_bit_cnt_nxt = c_BIT_TOP;
        end
      end
      SHIFT_HI: begin
        // The falling SCK edge presents the next bit; after bit 0 the
        // register is left alone so SDI holds the last bit through HOLD.
        if (w_tick && !w_last_bit) begin
          w_shreg_nxt   = {r_shreg[DATA_W-2:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt - c_BIT_ONE;
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_shreg_nxt = '0;
          w_done_nxt  = 1'b1;
        end
      end
      c_ST_GAP: begin
        if (!w_gap_end) begin
          w_gap_cnt_nxt = r_gap_cnt + c_GAP_ONE;
        end
      end
      default: begin
        w_shreg_nxt = r_shreg;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Outputs decoded from registered state only; tx_valid never reaches a pin.
  always_comb begin
    o_tx_ready  = (r_state == IDLE);
    o_tx_done   = r_done;
    o_ssdec_ss  = !w_busy;
    o_ssdec_sck = (r_state == SHIFT_HI);
    o_ssdec_sdi = w_busy & r_shreg[DATA_W-1];
  end

endmodule : t07_ssdec_spi_tx
`default_nettype wire

// File: tb/tb_t07_ssdec_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_t07_ssdec_spi_tx
// Purpose  : Scoreboard bench. Instance A uses a small configuration
//            (8-bit frame, HALF_DIV=2, GAP=3), instance B the defaults.
//            Accepted frames are queued; an SPI-slave monitor per instance
//            captures frames from the pins and compares them.
// Revision : 1.0  initial release
// ============================================================================
module tb_t07_ssdec_spi_tx;

  localparam int AW = 8;
  localparam int AH = 2;
  localparam int AG = 3;
  localparam int BW = 16;
  localparam int BH = 6;
  localparam int BG = 4;
  // Select-low window: DATA_W full SCK periods plus one HOLD half-period.
  localparam int A_LOW = 2 * AH * AW + AH;  // 34
  localparam int B_LOW = 2 * BH * BW + BH;  // 198

  logic          clk  = 1'b0;
  logic          nrst = 1'b0;
  logic          va   = 1'b0;
  logic [AW-1:0] da   = '0;
  logic          vb   = 1'b0;
  logic [BW-1:0] db   = '0;
  logic          ra, dna, sdia, scka, ssa;
  logic          rb, dnb, sdib, sckb, ssb;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  t07_ssdec_spi_tx #(.DATA_W(AW), .HALF_DIV(AH), .GAP(AG)) dut_a (
    .clk(clk), .nrst(nrst), .i_tx_valid(va), .i_tx_data(da),
    .o_tx_ready(ra), .o_tx_done(dna), .o_ssdec_sdi(sdia),
    .o_ssdec_sck(scka), .o_ssdec_ss(ssa)
  );

  t07_ssdec_spi_tx dut_b (
    .clk(clk), .nrst(nrst), .i_tx_valid(vb), .i_tx_data(db),
    .o_tx_ready(rb), .o_tx_done(dnb), .o_ssdec_sdi(sdib),
    .o_ssdec_sck(sckb), .o_ssdec_ss(ssb)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard: accepted frames ----------------
  logic [AW-1:0] qa[$];
  logic [BW-1:0] qb[$];
  int acc_a = 0, acc_b = 0, acc_cyc_a = 0, acc_cyc_b = 0;
  bit pend_a = 0, pend_b = 0;

  always @(posedge clk) begin
    cyc++;
    if (nrst && va && ra) begin qa.push_back(da); acc_a++; acc_cyc_a = cyc; pend_a = 1; end
    if (nrst && vb && rb) begin qb.push_back(db); acc_b++; acc_cyc_b = cyc; pend_b = 1; end
  end

  // ---------------- SPI-slave monitor, instance A ----------------
  logic [AW-1:0] cap_a = '0;
  int   bits_a = 0, low_a = 0, hi_a = 0, gap_a = 0, frames_a = 0, dones_a = 0;
  logic pss_a = 1'b1, psck_a = 1'b0, psdi_a = 1'b0, pr_a = 1'b1;

  always @(negedge clk) begin
    if (!nrst) begin
      qa.delete(); pend_a = 0; bits_a = 0; low_a = 0; hi_a = 0;
      pss_a = 1'b1; psck_a = 1'b0; psdi_a = 1'b0; pr_a = 1'b1;
    end else begin
      if (dna) dones_a++;
      if (!ssa) begin
        if (pss_a) begin gap_a = hi_a; bits_a = 0; low_a = 0; end
        low_a++;
        if (scka && !psck_a) begin
          chk("A sdi setup", sdia, psdi_a);
          cap_a = {cap_a[AW-2:0], sdia};
          bits_a++;
        end else if (scka) begin
          chk("A sdi hold", sdia, psdi_a);
        end
        chk("A done while busy", dna, 0);
      end else begin
        if (!pss_a) begin
          chk("A done at ss rise", dna, 1);
          chk("A sck rising edges", bits_a, AW);
          chk("A ss low cycles", low_a, A_LOW);
          if (qa.size() == 0) chk("A unexpected frame", 1, 0);
          else chk("A frame data", cap_a, qa.pop_front());
          frames_a++;
          hi_a = 0;
        end else begin
          chk("A done idle", dna, 0);
        end
        hi_a++;
        chk("A sck idle", scka, 0);
        chk("A sdi idle", sdia, 0);
      end
      if (ra && !pr_a && pend_a) begin
        chk("A accept to ready", cyc - acc_cyc_a, A_LOW + AG);
        pend_a = 0;
      end
      pss_a = ssa; psck_a = scka; psdi_a = sdia; pr_a = ra;
    end
  end

  // ---------------- SPI-slave monitor, instance B ----------------
  logic [BW-1:0] cap_b = '0;
  int   bits_b = 0, low_b = 0, frames_b = 0, dones_b = 0;
  logic pss_b = 1'b1, psck_b = 1'b0, psdi_b = 1'b0, pr_b = 1'b1;

  always @(negedge clk) begin
    if (!nrst) begin
      qb.delete(); pend_b = 0; bits_b = 0; low_b = 0;
      pss_b = 1'b1; psck_b = 1'b0; psdi_b = 1'b0; pr_b = 1'b1;
    end else begin
      if (dnb) dones_b++;
      if (!ssb) begin
        if (pss_b) begin bits_b = 0; low_b = 0; end
        low_b++;
        if (sckb && !psck_b) begin
          chk("B sdi setup", sdib, psdi_b);
          cap_b = {cap_b[BW-2:0], sdib};
          bits_b++;
        end else if (sckb) begin
          chk("B sdi hold", sdib, psdi_b);
        end
      end else if (!pss_b) begin
        chk("B done at ss rise", dnb, 1);
        chk("B sck rising edges", bits_b, BW);
        chk("B ss low cycles", low_b, B_LOW);
        if (qb.size() == 0) chk("B unexpected frame", 1, 0);
        else chk("B frame data", cap_b, qb.pop_front());
        frames_b++;
      end else begin
        chk("B idle lines", {dnb, sckb, sdib}, 0);
      end
      if (rb && !pr_b && pend_b) begin
        chk("B accept to ready", cyc - acc_cyc_b, B_LOW + BG);
        pend_b = 0;
      end
      pss_b = ssb; psck_b = sckb; psdi_b = sdib; pr_b = rb;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int sel, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (!(sel == 0 ? ra : rb)) begin
      @(negedge clk);
      n++;
      if (n > 1000) begin chk("send ready timeout", 0, 1); return; end
    end
    if (sel == 0) begin va = 1'b1; da = d[AW-1:0]; end
    else begin vb = 1'b1; db = d; end
    @(negedge clk);
    va = 1'b0; vb = 1'b0;
  endtask

  task automatic wait_frames(input int sel, input int target);
    int n = 0;
    while ((sel == 0 ? frames_a : frames_b) < target) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin chk("frame wait timeout", 0, 1); return; end
    end
  endtask

  task automatic wait_acc_a(input int target);
    int n = 0;
    while (acc_a < target) begin
      @(negedge clk);
      n++;
      if (n > 1000) begin chk("accept wait timeout", 0, 1); return; end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] r;

    // Reset values while nrst is held low.
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset A ready", ra, 1);
    chk("reset A ss", ssa, 1);
    chk("reset A sck/sdi/done", {scka, sdia, dna}, 0);
    chk("reset B ready", rb, 1);
    chk("reset B lines", {ssb, sckb, sdib, dnb}, 4'b1000);
    nrst = 1'b1;

    // Idle for 20 cycles: nothing moves.
    repeat (20) begin
      @(negedge clk);
      chk("idle A ready/ss", {ra, ssa}, 2'b11);
      chk("idle B ready/ss", {rb, ssb}, 2'b11);
    end

    // Single frame on the small configuration.
    send(0, 16'h00A5);
    wait_frames(0, 1);

    // Default configuration frame.
    send(1, 16'h0B35);
    wait_frames(1, 1);

    // Valid held high: two back-to-back frames, data swapped after accept.
    @(negedge clk);
    va = 1'b1; da = 8'h3C;
    wait_acc_a(2);
    @(negedge clk);
    da = 8'hC3;
    wait_acc_a(3);
    @(negedge clk);
    va = 1'b0;
    wait_frames(0, 3);
    chk("A back-to-back ss high", gap_a, AG + 1);

    // Reset after the 5th SCK rising edge aborts the frame.
    send(0, 16'h005A);
    repeat (2) @(negedge clk);
    n = 0;
    while (bits_a < 5 && n < 200) begin @(negedge clk); n++; end
    chk("A reached 5th edge", bits_a, 5);
    nrst = 1'b0;
    @(negedge clk);
    chk("abort A ss/sck", {ssa, scka}, 2'b10);
    chk("abort A done/sdi", {dna, sdia}, 0);
    chk("abort A ready", ra, 1);
    @(negedge clk);
    nrst = 1'b1;
    send(0, 16'h00FF);
    wait_frames(0, 4);
    chk("A frames after abort", frames_a, 4);
    chk("A dones after abort", dones_a, 4);

    // Valid pulsed mid-frame is ignored.
    send(0, 16'h0096);
    repeat (10) @(negedge clk);
    va = 1'b1; da = 8'h00;
    @(negedge clk);
    va = 1'b0;
    wait_frames(0, 5);
    repeat (60) @(negedge clk);
    chk("A frames busy-valid", frames_a, 5);
    chk("A dones busy-valid", dones_a, 5);

    // Random frames on both instances.
    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      send(0, r);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_frames(0, 11);
    for (int i = 0; i < 3; i++) begin
      send(1, t07_ssdec_pkg::pack_frame(2'($urandom_range(0, 3)),
                                        3'($urandom_range(0, 7)),
                                        3'($urandom_range(0, 5)),
                                        4'($urandom_range(0, 9))));
    end
    wait_frames(1, 4);
    repeat (10) @(negedge clk);
    chk("A total frames", frames_a, 11);
    chk("B total frames", frames_b, 4);
    chk("B total dones", dones_b, 4);
    chk("A queue drained", qa.size(), 0);
    chk("B queue drained", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_t07_ssdec_spi_tx
`default_nettype wire
